// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx serializer among NREQ byte producers.
// Grants one request per frame and holds off further grants until the frame completes.
module uart_tx_arbiter #(
    parameter  int NREQ         = 4,
    parameter  int DATA_W       = 8,
    parameter  int CLKS_PER_BIT = 16,
    localparam int PTR_W        = $clog2(NREQ),
    localparam int FRAME_CYCLES = 10 * CLKS_PER_BIT,
    localparam int CNT_W        = $clog2(FRAME_CYCLES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DATA_W-1:0]   data,
    output logic [NREQ-1:0]          ack,
    output logic [DATA_W-1:0]        tx_din,
    output logic                     tx_send,
    output logic                     busy,
    output logic [PTR_W-1:0]         grant_id,
    output logic [15:0]              sent_cnt
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]        r_state;
    logic [PTR_W-1:0]  r_rr_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic [NREQ-1:0]   r_ack;
    logic [DATA_W-1:0] r_tx_din;
    logic              r_tx_send;
    logic [PTR_W-1:0]  r_grant_id;
    logic [15:0]       r_sent_cnt;

    logic [PTR_W-1:0]  w_sel;
    logic              w_found;
    logic [PTR_W-1:0]  w_next_ptr;

    // Scan from the highest offset down so the requester closest to rr_ptr wins last.
    always_comb begin : arb_scan
        int idx;
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_sel   = r_rr_ptr;
        w_found = 1'b0;
        idx     = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = (int'(r_rr_ptr) + i) % NREQ;
            if (req[idx]) begin
                w_sel   = PTR_W'(idx);
                w_found = 1'b1;
            end
        end
    end

    assign w_next_ptr = (w_sel == PTR_W'(NREQ - 1)) ? '0 : w_sel + PTR_W'(1);

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_cnt      <= '0;
            r_ack      <= '0;
            r_tx_din   <= '0;
            r_tx_send  <= 1'b0;
            r_grant_id <= '0;
            r_sent_cnt <= '0;
        end else begin
            r_ack     <= '0;
            r_tx_send <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_tx_din        <= data[w_sel*DATA_W +: DATA_W];
                        r_grant_id      <= w_sel;
                        r_ack[w_sel]    <= 1'b1;
                        r_tx_send       <= 1'b1;
                        r_sent_cnt      <= r_sent_cnt + 16'd1;
                        r_cnt           <= CNT_W'(FRAME_CYCLES - 1);
                        r_state         <= ST_WAIT;
                        r_rr_ptr        <= w_next_ptr;
                    end
                end
                ST_WAIT: begin
                    // The frame occupies exactly FRAME_CYCLES cycles of WAIT.
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ack      = r_ack;
    assign tx_din   = r_tx_din;
    assign tx_send  = r_tx_send;
    assign busy     = (r_state == ST_WAIT);
    assign grant_id = r_grant_id;
    assign sent_cnt = r_sent_cnt;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: table-driven grant vectors plus hand-written
// sequences for reset, frame length, mid-frame abort and counter wrap.
module tb_uart_tx_arbiter;

    localparam int NREQ         = 4;
    localparam int DATA_W       = 8;
    localparam int CLKS_PER_BIT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] data = '0;
    logic [3:0]  ack;
    logic [7:0]  tx_din;
    logic        tx_send;
    logic        busy;
    logic [1:0]  grant_id;
    logic [15:0] sent_cnt;

    int n_vec  = 0;
    int n_err  = 0;
    int n_viol = 0;
    int cyc    = 0;

    uart_tx_arbiter #(
        .NREQ        (NREQ),
        .DATA_W      (DATA_W),
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .data    (data),
        .ack     (ack),
        .tx_din  (tx_din),
        .tx_send (tx_send),
        .busy    (busy),
        .grant_id(grant_id),
        .sent_cnt(sent_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Pulse-shape watcher: ack and tx_send coincident, one-hot, single cycle.
    logic prev_send = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            if ((ack != 4'b0) != tx_send) n_viol++;
            if (tx_send && $countones(ack) != 1) n_viol++;
            if (tx_send && prev_send) n_viol++;
            prev_send = tx_send;
        end else begin
            prev_send = 1'b0;
        end
    end

    typedef struct {
        logic        rst_before;
        logic [3:0]  req;
        logic [31:0] data;
        int          exp_id;
        logic [7:0]  exp_din;
        int          exp_cnt;
        int          exp_gap;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Bounded wait for tx_send, sampled on falling edges; returns cycles waited.
    task automatic wait_send(output int waited);
        logic seen;
        seen   = 1'b0;
        waited = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            waited++;
            if (tx_send) begin
                seen = 1'b1;
                break;
            end
        end
        check("send_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        int waited;
        int nz;
        int nb;
        int bad;
        int sends;
        int last_send_cyc;

        vecs[0] = '{1'b1, 4'hF, 32'h413F3521, 0, 8'h21, 1, 0};
        vecs[1] = '{1'b0, 4'hF, 32'h413F3521, 1, 8'h35, 2, 21};
        vecs[2] = '{1'b0, 4'hF, 32'h413F3521, 2, 8'h3F, 3, 21};
        vecs[3] = '{1'b0, 4'hF, 32'h413F3521, 3, 8'h41, 4, 21};
        vecs[4] = '{1'b0, 4'hF, 32'h413F3521, 0, 8'h21, 5, 21};
        vecs[5] = '{1'b1, 4'b0001, 32'h44332211, 0, 8'h11, 1, 0};
        vecs[6] = '{1'b0, 4'b1001, 32'h44332211, 3, 8'h44, 2, 21};
        vecs[7] = '{1'b0, 4'b1001, 32'h44332211, 0, 8'h11, 3, 21};

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b0;
        #2;
        check("rst_async_busy", 32'(busy), 32'd0);
        check("rst_async_cnt", 32'(sent_cnt), 32'd0);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req  = 4'($urandom);
            data = $urandom;
        end
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_tx_send", 32'(tx_send), 32'd0);
        check("rst_tx_din", 32'(tx_din), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_sent_cnt", 32'(sent_cnt), 32'd0);

        req = '0;
        rst = 1'b1;
        nz  = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            data = $urandom;
            if (ack != 0 || tx_send || tx_din != 0 || busy || grant_id != 0 || sent_cnt != 0) nz++;
        end
        check("idle_quiet", 32'(nz), 32'd0);

        // Single requester: grant latency, frame length, tx_din stability.
        req  = 4'b0100;
        data = {8'hC3, 8'h35, 8'h7E, 8'h99};
        wait_send(waited);
        check("single_latency", 32'(waited), 32'd1);
        check("single_ack", 32'(ack), 32'h4);
        check("single_tx_din", 32'(tx_din), 32'h35);
        check("single_grant_id", 32'(grant_id), 32'd2);
        check("single_busy", 32'(busy), 32'd1);
        check("single_sent_cnt", 32'(sent_cnt), 32'd1);
        req = '0;
        nb  = 0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) nb++;
            if (tx_din !== 8'h35) bad++;
            data = $urandom;
            @(negedge clk);
        end
        check("single_busy_len", 32'(nb), 32'd20);
        check("single_din_stable", 32'(bad), 32'd0);

        // Round-robin and pointer-rotation vectors.
        last_send_cyc = 0;
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].rst_before) do_reset();
            req  = vecs[v].req;
            data = vecs[v].data;
            wait_send(waited);
            check($sformatf("v%0d_grant_id", v), 32'(grant_id), 32'(vecs[v].exp_id));
            check($sformatf("v%0d_ack", v), 32'(ack), 32'(1 << vecs[v].exp_id));
            check($sformatf("v%0d_tx_din", v), 32'(tx_din), 32'(vecs[v].exp_din));
            check($sformatf("v%0d_sent_cnt", v), 32'(sent_cnt), 32'(vecs[v].exp_cnt));
            if (vecs[v].exp_gap != 0)
                check($sformatf("v%0d_gap", v), 32'(cyc - last_send_cyc), 32'(vecs[v].exp_gap));
            last_send_cyc = cyc;
        end
        req = '0;

        // Mid-frame reset aborts immediately, nothing relaunched.
        do_reset();
        req  = 4'b0001;
        data = 32'h000000AA;
        wait_send(waited);
        req = '0;
        repeat (5) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ack", 32'(ack), 32'd0);
        check("abort_tx_send", 32'(tx_send), 32'd0);
        check("abort_sent_cnt", 32'(sent_cnt), 32'd0);
        @(negedge clk);
        rst   = 1'b1;
        sends = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx_send) sends++;
        end
        check("abort_no_resend", 32'(sends), 32'd0);

        // sent_cnt wraps from 0xFFFF to 0x0000.
        @(negedge clk);
        force dut.r_sent_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_sent_cnt;
        @(negedge clk);
        check("wrap_preset", 32'(sent_cnt), 32'hFFFF);
        req  = 4'b0010;
        data = 32'h00005A00;
        wait_send(waited);
        check("wrap_sent_cnt", 32'(sent_cnt), 32'h0000);
        check("wrap_grant_id", 32'(grant_id), 32'd1);
        check("wrap_tx_din", 32'(tx_din), 32'h5A);
        req = '0;
        repeat (25) @(negedge clk);

        check("pulse_shape", 32'(n_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
